// File: rtl/crossing_request_conditioner_if.sv
// crossing_request_conditioner_if
//
// Request/acknowledge handshake between the crossing request conditioner
// and the traffic-light controller.
//
// Signals:
//   switch [1:0]  latched pending crossing requests (conditioner -> controller)
//   ack    [1:0]  one-cycle "request served" pulse per channel (controller -> conditioner)
//   tick          one-cycle timing enable (conditioner -> controller)
//
// Modports:
//   master  the conditioner side (drives switch and tick, receives ack)
//   slave   the controller side (receives switch and tick, drives ack)
interface crossing_request_conditioner_if;
    logic [1:0] switch;
    logic [1:0] ack;
    logic       tick;

    modport master (output switch, output tick, input ack);
    modport slave  (input switch, input tick, output ack);
endinterface

// File: rtl/crossing_request_conditioner.sv
// crossing_request_conditioner
//
// Front end for the intersection controller. It synchronizes and debounces
// the two raw pedestrian buttons and turns each accepted press into a
// pending request that stays latched until the controller acknowledges it.
// It also produces the free-running tick enable that paces the controller,
// and ignores new presses on a channel for a programmable number of ticks
// after that channel has been served.
//
// Parameters:
//   TICK_DIV         clk cycles per tick period (>= 2)
//   DEBOUNCE_CYCLES  stable cycles needed to accept a button level change (>= 1)
//   HOLDOFF_TICKS    ticks during which presses are ignored after an ack (0 = off)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   btn_raw    raw asynchronous buttons, [0] = N/S, [1] = E/W, active high
//   btn_clean  debounced button levels
//   bus        handshake interface (master side): switch, tick out; ack in
module crossing_request_conditioner #(
    parameter int TICK_DIV        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLDOFF_TICKS   = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [1:0]                          btn_raw,
    output logic [1:0]                          btn_clean,
    crossing_request_conditioner_if.master      bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLDOFF_TICKS > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_TICKS);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_q;

    logic [1:0]        sync_s1;
    logic [1:0]        sync_s2;
    logic [DB_W-1:0]   db_cnt [2];
    logic [1:0]        clean_q;
    logic [1:0]        clean_d;

    logic [1:0]        switch_q;
    logic [HOLD_W-1:0] hold_cnt [2];

    logic [1:0]        rise;

    // Free-running tick generator; tick is registered so it fires in the
    // cycle after the counter sits at its last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= (tick_cnt == TICK_LAST);
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Two-flop synchronizer followed by a per-channel debounce counter that
    // only runs while the synchronized level disagrees with the clean level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            clean_q <= '0;
            clean_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_s1 <= btn_raw;
            sync_s2 <= sync_s1;
            clean_d <= clean_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_s2[i] == clean_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    clean_q[i] <= sync_s2[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only a press (rising clean edge) can raise a request.
    assign rise = clean_q & ~clean_d;

    // Request latch and holdoff. A new press wins over a same-cycle ack, so
    // the request stays set and holdoff is not armed. Presses arriving while
    // holdoff is nonzero are dropped rather than remembered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            switch_q <= '0;
            for (int i = 0; i < 2; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rise[i] && (hold_cnt[i] == '0)) begin
                    switch_q[i] <= 1'b1;
                end else if (bus.ack[i] && switch_q[i]) begin
                    switch_q[i] <= 1'b0;
                    hold_cnt[i] <= HOLD_LOAD;
                end else if (tick_q && (hold_cnt[i] != '0)) begin
                    hold_cnt[i] <= hold_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign bus.switch = switch_q;
    assign bus.tick   = tick_q;
    assign btn_clean  = clean_q;

endmodule

// File: tb/tb_crossing_request_conditioner.sv
// tb_crossing_request_conditioner
//
// Self-checking bench for crossing_request_conditioner with small parameters
// (TICK_DIV=10, DEBOUNCE_CYCLES=4, HOLDOFF_TICKS=2). A behavioural model of
// the button/request/tick rules is compared against the DUT every cycle,
// and directed sequences pin key latencies with literal expectations before
// a randomized phase with a mid-run asynchronous reset.
module tb_crossing_request_conditioner;

    localparam int TD   = 10;
    localparam int DB   = 4;
    localparam int HOLD = 2;

    logic       clk;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] btn_clean;

    crossing_request_conditioner_if bus ();

    crossing_request_conditioner #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DB),
        .HOLDOFF_TICKS   (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_clean (btn_clean),
        .bus       (bus.master)
    );

    int checks_total  = 0;
    int checks_passed = 0;
    bit model_on      = 1'b0;

    // Behavioural model state
    logic [1:0] m_pipe0, m_pipe1, m_clean, m_clean_prev, m_switch;
    logic       m_tick;
    int         m_run [2];
    int         m_hold [2];
    int         m_cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] raw, input logic [1:0] ackv);
        @(negedge clk);
        btn_raw = raw;
        bus.ack = ackv;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a press is accepted after the synchronized level has disagreed
    // with the clean level for DB consecutive cycles; requests, holdoff and
    // tick follow the handshake rules using pre-edge values.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pipe0 = '0; m_pipe1 = '0; m_clean = '0; m_clean_prev = '0;
            m_switch = '0; m_tick = 1'b0; m_cycles = 0;
            for (int i = 0; i < 2; i++) begin
                m_run[i]  = 0;
                m_hold[i] = 0;
            end
        end else begin
            logic [1:0] press;
            press = m_clean & ~m_clean_prev;
            for (int i = 0; i < 2; i++) begin
                bit accept;
                accept = press[i] && (m_hold[i] == 0);
                if (accept) begin
                    m_switch[i] = 1'b1;
                end else if (bus.ack[i] && m_switch[i]) begin
                    m_switch[i] = 1'b0;
                    m_hold[i]   = HOLD;
                end else if (m_tick && m_hold[i] > 0) begin
                    m_hold[i] = m_hold[i] - 1;
                end
            end
            m_clean_prev = m_clean;
            for (int i = 0; i < 2; i++) begin
                if (m_pipe1[i] != m_clean[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_clean[i] = m_pipe1[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pipe1  = m_pipe0;
            m_pipe0  = btn_raw;
            m_cycles = m_cycles + 1;
            m_tick   = (m_cycles % TD) == 0;
        end
    end

    // Compare process: DUT against model on every cycle once enabled.
    always @(posedge clk) begin
        #1;
        if (model_on) begin
            check_output("model_switch", {30'd0, bus.switch}, {30'd0, m_switch});
            check_output("model_btn_clean", {30'd0, btn_clean}, {30'd0, m_clean});
            check_output("model_tick", {31'd0, bus.tick}, {31'd0, m_tick});
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] raw_state;
        int         dur [2];

        reset   = 1'b0;
        btn_raw = 2'b00;
        bus.ack = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_switch", {30'd0, bus.switch}, 32'd0);
        check_output("reset_clean", {30'd0, btn_clean}, 32'd0);
        check_output("reset_tick", {31'd0, bus.tick}, 32'd0);

        // Tick cadence with no buttons
        @(negedge clk);
        reset    = 1'b1;
        model_on = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            wait_edges(1);
            check_output("tick_cadence", {31'd0, bus.tick}, ((e % TD) == 0) ? 32'd1 : 32'd0);
        end
        check_output("idle_switch", {30'd0, bus.switch}, 32'd0);

        // Press latency on channel 0
        apply_stimulus(2'b01, 2'b00);
        wait_edges(5);
        check_output("clean_before_latency", {30'd0, btn_clean}, 32'd0);
        wait_edges(1);
        check_output("clean_at_latency", {30'd0, btn_clean}, 32'd1);
        check_output("switch_before_latency", {30'd0, bus.switch}, 32'd0);
        wait_edges(1);
        check_output("switch_at_latency", {30'd0, bus.switch}, 32'd1);

        // Short glitch on channel 1 is filtered
        apply_stimulus(2'b11, 2'b00);
        wait_edges(3);
        apply_stimulus(2'b01, 2'b00);
        wait_edges(10);
        check_output("glitch_filtered", {30'd0, bus.switch}, 32'd1);

        // Release does not touch the request
        apply_stimulus(2'b00, 2'b00);
        wait_edges(8);
        check_output("release_clean", {30'd0, btn_clean}, 32'd0);
        check_output("release_keeps_switch", {30'd0, bus.switch}, 32'd1);

        // Ack clears; ack with no request is ignored
        apply_stimulus(2'b00, 2'b01);
        apply_stimulus(2'b00, 2'b00);
        check_output("ack_clears", {30'd0, bus.switch}, 32'd0);
        apply_stimulus(2'b00, 2'b10);
        apply_stimulus(2'b00, 2'b00);
        check_output("ack_idle_noop", {30'd0, bus.switch}, 32'd0);

        // Press during holdoff is discarded
        apply_stimulus(2'b01, 2'b00);
        wait_edges(7);
        check_output("holdoff_discard", {30'd0, bus.switch}, 32'd0);
        apply_stimulus(2'b00, 2'b00);
        wait_edges(25);
        apply_stimulus(2'b01, 2'b00);
        wait_edges(6);
        check_output("post_holdoff_early", {30'd0, bus.switch}, 32'd0);
        wait_edges(1);
        check_output("post_holdoff_accept", {30'd0, bus.switch}, 32'd1);

        // Set and ack in the same cycle: set wins, no holdoff
        apply_stimulus(2'b11, 2'b00);
        wait_edges(7);
        check_output("ch1_request", {30'd0, bus.switch}, 32'd3);
        apply_stimulus(2'b01, 2'b00);
        wait_edges(8);
        apply_stimulus(2'b11, 2'b00);
        wait_edges(6);
        apply_stimulus(2'b11, 2'b10);
        wait_edges(1);
        check_output("set_beats_ack", {30'd0, bus.switch}, 32'd3);
        apply_stimulus(2'b11, 2'b10);
        apply_stimulus(2'b11, 2'b00);
        check_output("reack_clears", {30'd0, bus.switch}, 32'd1);

        // Asynchronous reset mid-debounce with both requests pending
        apply_stimulus(2'b01, 2'b00);
        wait_edges(30);
        apply_stimulus(2'b11, 2'b00);
        wait_edges(7);
        check_output("both_pending", {30'd0, bus.switch}, 32'd3);
        apply_stimulus(2'b10, 2'b00);
        wait_edges(2);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_switch", {30'd0, bus.switch}, 32'd0);
        check_output("async_clean", {30'd0, btn_clean}, 32'd0);
        check_output("async_tick", {31'd0, bus.tick}, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        btn_raw = 2'b11;
        bus.ack = 2'b00;
        wait_edges(6);
        check_output("rereq_early", {30'd0, bus.switch}, 32'd0);
        wait_edges(1);
        check_output("rereq_after_reset", {30'd0, bus.switch}, 32'd3);

        // Randomized phase against the model
        raw_state = 2'b11;
        dur[0] = 0;
        dur[1] = 0;
        for (int c = 0; c < 2500; c++) begin
            logic [1:0] ackv;
            for (int i = 0; i < 2; i++) begin
                if (dur[i] == 0) begin
                    raw_state[i] = 1'($urandom_range(0, 1));
                    dur[i] = int'($urandom_range(1, 12));
                end else begin
                    dur[i] = dur[i] - 1;
                end
                ackv[i] = ($urandom_range(0, 7) == 0);
            end
            if (c == 1200) begin
                @(posedge clk);
                #3;
                reset = 1'b0;
                #1;
                check_output("random_async_reset", {30'd0, bus.switch}, 32'd0);
                @(negedge clk);
                reset = 1'b1;
            end
            apply_stimulus(raw_state, ackv);
        end
        apply_stimulus(raw_state, 2'b00);
        wait_edges(2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/crossing_request_conditioner.md
# crossing_request_conditioner

Upstream conditioning stage for the intersection traffic-light controller. Synchronizes and debounces the two raw pedestrian crossing buttons and latches each press as a pending request on `switch[1:0]` until the controller acknowledges it. Generates the one-second `tick` enable that paces the controller's state timing, and holds off repeat requests for a programmable number of ticks after each service.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per tick period; must be ≥2.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change; must be ≥1.
- `HOLDOFF_TICKS`, default 5: ticks during which new presses are ignored after an ack; 0 disables holdoff.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset; the block is held in reset while `reset`=0.
- `btn_raw`  in  2  raw, asynchronous buttons, active-high; [0]=N/S crossing, [1]=E/W crossing.
- `ack`  in  2  from the controller, 1-cycle pulse per channel: request served.
- `switch`  out  2  latched pending requests to the controller.
- `btn_clean`  out  2  debounced button level.
- `tick`  out  1  one-cycle pulse every `TICK_DIV` cycles.

## Operation
- Reset (`reset`=0, asynchronous): sync flops, `btn_clean`, edge-detect register, `switch`, `tick`, debounce counters, holdoff counters and tick counter all clear to 0.
- Synchronizer: two flops per channel, `s1`→`s2`.
- Debounce, per channel: counter clears whenever `s2`==`btn_clean`. While they differ, the counter increments each cycle. On the edge where the counter equals `DEBOUNCE_CYCLES`-1 and the inputs still differ, `btn_clean` takes `s2` and the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `btn_clean`.
- Press detect: `rise[i]` = `btn_clean[i]` & ~`btn_clean_d[i]`, where `btn_clean_d` is the previous-cycle register. Only rising edges matter; button release has no effect on `switch`.
- Request latch, per channel, priority order:
  - `rise` and holdoff=0 → `switch`=1. A set and an `ack` in the same cycle leave `switch`=1 and do not load holdoff.
  - `ack` with `switch`=1 → `switch`=0, and holdoff loads `HOLDOFF_TICKS`.
  - `ack` with `switch`=0 → no effect.
  - `rise` while holdoff≠0 → discarded, not queued.
- Holdoff counter: decrements by 1 on each `tick` cycle while nonzero. It saturates at 0.
- Tick generator: counter runs 0..`TICK_DIV`-1 and wraps. `tick`=1 is registered and asserted for exactly the one cycle after the counter reaches `TICK_DIV`-1. The tick counter is free-running and independent of buttons and `ack`.
- Counter widths: `$clog2` of the respective maximum, minimum 1 bit. No overflow is possible.

## Timing
- Press latency: if edge E0 is the first edge to sample `btn_raw[i]`=1 (held stable), `btn_clean[i]` rises after E0+`DEBOUNCE_CYCLES`+1 and `switch[i]` rises after E0+`DEBOUNCE_CYCLES`+2.
- Release latency: `btn_clean[i]` falls after E0+`DEBOUNCE_CYCLES`+1, where E0 is the first edge to sample 0.
- `ack` clears `switch` on the same edge that samples `ack`; `switch` reads 0 the following cycle.
- First `tick` after reset deasserts: high after the `TICK_DIV`-th rising edge. Thereafter it repeats with period `TICK_DIV`.
- Holdoff of H ticks ends on the H-th `tick` after the ack. A press whose `rise` occurs in the cycle after that tick is accepted.
- Reset asserted mid-debounce or mid-holdoff: all state is lost immediately. A button held through reset release re-debounces from 0 and produces a new request.

## Test plan
1. `TICK_DIV`=10, no buttons → `tick` pulses after edges 10, 20, 30; pulse width 1 cycle; `switch`=00 throughout.
2. `DEBOUNCE_CYCLES`=4; hold `btn_raw[0]`=1 from E0 → `btn_clean[0]`=1 after E5, `switch`=01 after E6. A 3-cycle pulse on `btn_raw[1]` → `switch[1]` stays 0.
3. `switch`=01, pulse `ack`=01 → `switch`=00 next cycle. `ack`=10 while `switch[1]`=0 → no change, no holdoff.
4. `HOLDOFF_TICKS`=2, `TICK_DIV`=10: ack channel 0, then press during the first 2 ticks → ignored. Press after the 2nd tick → `switch[0]`=1 at the debounce-latency edge.
5. `rise[1]` and `ack[1]` in the same cycle with `switch[1]`=1 → `switch[1]` stays 1, and an immediate re-ack clears it.
6. Drive `reset`=0 asynchronously mid-debounce with `switch`=11 → all outputs 0 without a clock edge. Button held through release → `switch` re-asserts `DEBOUNCE_CYCLES`+2 edges after release.
